alu_issue_queue: RTL
====================

Name: alu_issue_queue

Overview:
- Upstream command buffer for the 128-bit combinational ALU (opcodes ADD, SUB, AND, OR, SLL, SRL, XNOR, DIV).
- Accepts ALU commands over a valid/ready handshake and queues them in a small circular FIFO.
- Presents the head command on the ALU operand ports (opcode, input1, input2, shiftValue) with an issue valid/ready handshake toward the result-capture stage.
- Filters illegal opcodes and flags divide-by-zero commands before they reach the ALU.

Parameters:
- WIDTH, 128, operand width.
- DEPTH, 4, FIFO entries; must be a power of two, at least 2.
- OPW, 4, opcode width.
- SHW, 5, shift-amount width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous queue clear.
- in_valid  in  1  command offered.
- in_ready  out  1  queue can accept this cycle.
- in_opcode  in  OPW  command opcode.
- in_op1  in  WIDTH  first operand.
- in_op2  in  WIDTH  second operand.
- in_shift  in  SHW  shift amount.
- alu_valid  out  1  head command presented.
- alu_ready  in  1  downstream consumes head this cycle.
- alu_opcode  out  OPW  head opcode; drives ALU opcode.
- alu_input1  out  WIDTH  head first operand; drives ALU input1.
- alu_input2  out  WIDTH  head second operand; drives ALU input2.
- alu_shiftValue  out  SHW  head shift amount; drives ALU shiftValue.
- alu_div0  out  1  head is DIV with op2 == 0.
- count  out  $clog2(DEPTH)+1  current occupancy.
- err_illegal  out  1  sticky: an opcode > 7 was offered.
- issued_cnt  out  16  number of commands issued; wraps.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Write and read pointers, count, err_illegal and issued_cnt go to 0.
  - alu_valid = 0.
  - Storage array is not reset.
- Push and pop conditions:
  - push = in_valid & in_ready & (in_opcode <= 7).
  - pop = alu_valid & alu_ready.
- in_ready = !full | alu_ready. A push into a full queue is allowed in the same cycle as a pop. Combinational path from alu_ready to in_ready is permitted.
- Illegal opcode handling:
  - An opcode > 7 offered with in_valid & in_ready is consumed and dropped; no entry is written.
  - err_illegal is set on the next edge and holds until flush or reset.
- Latency:
  - A command accepted at edge N appears on alu_* after edge N when the queue was empty.
  - There is no bypass. Minimum in-to-issue latency is 1 cycle.
- Throughput: one push and one pop per cycle sustained.
- Status outputs:
  - alu_valid = (count != 0).
  - When empty, alu_opcode, alu_input1, alu_input2 and alu_shiftValue are forced to 0 (ADD of zeros).
  - While alu_valid = 1 and alu_ready = 0, all alu_* outputs hold stable.
- alu_div0 is combinational from the head entry: (alu_opcode == DIV) & (alu_input2 == 0) & alu_valid. Such commands are still issued; the ALU returns 0 for them.
- Pointers wrap modulo DEPTH.
- Count update:
  - Push and pop together: count unchanged.
  - Push only: count + 1.
  - Pop only: count - 1.
  - Count never exceeds DEPTH and never goes below 0.
- issued_cnt increments on every pop and wraps 0xFFFF -> 0x0000.
- flush:
  - Has priority over push and pop in the same cycle.
  - Clears pointers, count and err_illegal; issued_cnt is kept.
  - The pop in a flush cycle is not counted.
  - alu_valid = 0 from the next cycle.
- An asynchronous reset mid-stream discards all queued commands. No partial state survives.

Decomposition:
- Package alu_pkg holds:
  - Opcode constants ADD=0, SUB=1, AND=2, OR=3, SLL=4, SRL=5, XNOR=6, DIV=7.
  - OPW=4 and SHW=5.
  - An alu_cmd struct {opcode, op1, op2, shift}.
- One sub-module, alu_cmd_fifo: a generic synchronous FIFO with pointers, count and flush, parameterised by payload width and DEPTH.
- alu_issue_queue wraps alu_cmd_fifo and adds opcode filtering, output zero-masking, div0 detection and issued_cnt.

Test Plan:
- Reset, then push ADD op1=5 op2=7 with alu_ready=0 -> next cycle alu_valid=1, alu_opcode=0, alu_input1=5, alu_input2=7, count=1; outputs stable for 3 stalled cycles.
- Push 4 commands with alu_ready=0 -> count=4, in_ready=0. Then assert in_valid and alu_ready together for 1 cycle -> a 5th command is accepted, count stays 4, issued_cnt=1.
- Push opcode 9, then SUB 10-3 -> err_illegal=1, count=1, head alu_opcode=1, alu_input1=10, alu_input2=3.
- Push DIV op1=100 op2=0 -> alu_div0=1 while at head. Push DIV 100/4 -> alu_div0=0 when that command reaches the head.
- Fill with 3 entries, assert flush together with in_valid and alu_ready -> next cycle count=0, alu_valid=0, alu_* all 0, err_illegal=0, issued_cnt unchanged.
- Stream 70000 commands with alu_ready=1 -> issued_cnt = 70000 mod 65536 = 4464; pointers wrap with no lost or duplicated entries, checked against a scoreboard.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, width and command types for the ALU issue queue
package alu_pkg;

    localparam int OPW   = 4;
    localparam int SHW   = 5;
    localparam int ALU_W = 128;

    typedef enum logic [OPW-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_SLL  = 4'd4,
        OP_SRL  = 4'd5,
        OP_XNOR = 4'd6,
        OP_DIV  = 4'd7
    } alu_op_e;

    typedef struct packed {
        logic [OPW-1:0]   opcode;
        logic [ALU_W-1:0] op1;
        logic [ALU_W-1:0] op2;
        logic [SHW-1:0]   shift;
    } alu_cmd_t;

    // Opcodes above DIV have no ALU meaning and are dropped at the queue input.
    function automatic logic is_legal_op(input logic [OPW-1:0] op);
        return op <= OP_DIV;
    endfunction

endpackage

// File: rtl/alu_issue_queue_if.sv
// rtl/alu_issue_queue_if.sv - command-in and issue-out handshake bundle
interface alu_issue_queue_if #(
    parameter int WIDTH = alu_pkg::ALU_W
);
    logic                     in_valid;
    logic                     in_ready;
    logic [alu_pkg::OPW-1:0]  in_opcode;
    logic [WIDTH-1:0]         in_op1;
    logic [WIDTH-1:0]         in_op2;
    logic [alu_pkg::SHW-1:0]  in_shift;

    logic                     alu_valid;
    logic                     alu_ready;
    logic [alu_pkg::OPW-1:0]  alu_opcode;
    logic [WIDTH-1:0]         alu_input1;
    logic [WIDTH-1:0]         alu_input2;
    logic [alu_pkg::SHW-1:0]  alu_shiftValue;
    logic                     alu_div0;

    modport slave (
        input  in_valid, in_opcode, in_op1, in_op2, in_shift, alu_ready,
        output in_ready, alu_valid, alu_opcode, alu_input1, alu_input2,
               alu_shiftValue, alu_div0
    );

    modport master (
        output in_valid, in_opcode, in_op1, in_op2, in_shift, alu_ready,
        input  in_ready, alu_valid, alu_opcode, alu_input1, alu_input2,
               alu_shiftValue, alu_div0
    );
endinterface

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - generic circular FIFO with occupancy count and synchronous flush
module alu_cmd_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            wdata,
    output logic [DW-1:0]            rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];

    // A push into a full queue only lands when the head leaves in the same cycle.
    assign push_ok = push & (~full | pop) & ~flush;
    assign pop_ok  = pop & ~empty & ~flush;

    // Next-state for storage, pointers and occupancy; flush wins over push/pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Payload storage carries no reset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/alu_issue_queue.sv
// rtl/alu_issue_queue.sv - command queue in front of the 128-bit ALU with opcode filter and div0 flag
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    alu_issue_queue_if.slave       bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err_illegal,
    output logic [15:0]            issued_cnt
);
    localparam int PW = OPW + 2 * WIDTH + SHW;

    logic [PW-1:0]    wdata, rdata;
    logic             fifo_full, fifo_empty;
    logic             offer, op_legal, push, pop;
    logic [OPW-1:0]   head_op;
    logic [WIDTH-1:0] head_op1, head_op2;
    logic [SHW-1:0]   head_sh;

    logic             err_illegal_q, err_illegal_d;
    logic [15:0]      issued_cnt_q, issued_cnt_d;

    assign wdata = {bus.in_opcode, bus.in_op1, bus.in_op2, bus.in_shift};
    assign {head_op, head_op1, head_op2, head_sh} = rdata;

    // A full queue still accepts when the head is consumed in the same cycle.
    assign bus.in_ready = ~fifo_full | bus.alu_ready;
    assign offer        = bus.in_valid & bus.in_ready;
    assign op_legal     = is_legal_op(bus.in_opcode);
    assign push         = offer & op_legal;
    assign pop          = bus.alu_valid & bus.alu_ready;

    alu_cmd_fifo #(
        .DW    (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Head presentation: zeroed when empty so the ALU sees a harmless ADD 0,0.
    always_comb begin
        bus.alu_valid      = ~fifo_empty;
        bus.alu_opcode     = '0;
        bus.alu_input1     = '0;
        bus.alu_input2     = '0;
        bus.alu_shiftValue = '0;
        bus.alu_div0       = 1'b0;
        if (!fifo_empty) begin
            bus.alu_opcode     = head_op;
            bus.alu_input1     = head_op1;
            bus.alu_input2     = head_op2;
            bus.alu_shiftValue = head_sh;
            bus.alu_div0       = (head_op == OP_DIV) && (head_op2 == '0);
        end
    end

    // Sticky illegal-opcode flag and wrapping issue counter; flush clears only the flag.
    always_comb begin
        err_illegal_d = err_illegal_q | (offer & ~op_legal);
        issued_cnt_d  = issued_cnt_q;
        if (pop && !flush) begin
            issued_cnt_d = issued_cnt_q + 16'd1;
        end
        if (flush) begin
            err_illegal_d = 1'b0;
        end
    end

    // Status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_illegal_q <= 1'b0;
            issued_cnt_q  <= '0;
        end else begin
            err_illegal_q <= err_illegal_d;
            issued_cnt_q  <= issued_cnt_d;
        end
    end

    assign err_illegal = err_illegal_q;
    assign issued_cnt  = issued_cnt_q;

endmodule
